regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 79 +++++++
 tb/tb_regfile_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with writeback bypass and per-register pending scoreboard
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   rd_issue,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            hazard,
  output logic            issue_accept,
  output logic [NREGS-1:0] busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] eff_busy;
  logic             wb_en;

  assign wb_en = wb_valid && (wb_rd != '0);

  // A register whose writeback lands this cycle is already resolved for readers.
  always_comb begin
    eff_busy = '0;
    for (int i = 0; i < NREGS; i++) begin
      eff_busy[i] = busy[i] && !(wb_valid && (wb_rd == AW'(i)));
    end
  end

  always_comb begin
    read_data1 = regs[rs1];
    if (reset || (rs1 == '0)) begin
      read_data1 = '0;
    end else if (wb_valid && (wb_rd == rs1)) begin
      read_data1 = wb_data;
    end
  end

  always_comb begin
    read_data2 = regs[rs2];
    if (reset || (rs2 == '0)) begin
      read_data2 = '0;
    end else if (wb_valid && (wb_rd == rs2)) begin
      read_data2 = wb_data;
    end
  end

  assign hazard = !reset && (eff_busy[rs1] || eff_busy[rs2] ||
                             (issue_valid && eff_busy[rd_issue]));
  assign issue_accept = issue_valid && !hazard && !reset;
  assign busy_vec = busy;

  // The set is ordered after the clear so a new producer wins on the same index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wb_en) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      if (issue_accept && (rd_issue != '0)) begin
        busy[rd_issue] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - bench for regfile_scoreboard at default and 32x16 parameters
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rdi, wbrd;
  logic        iv, wv;
  logic [63:0] wbd;

  logic [63:0] rd1_a, rd2_a;
  logic        hz_a, acc_a;
  logic [31:0] busy_a;
  logic [31:0] rd1_b, rd2_b;
  logic        hz_b, acc_b;
  logic [15:0] busy_b;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mreg  [2][32];
  logic        mbusy [2][32];

  always #5 clk = ~clk;

  regfile_scoreboard dut_a (
    .clk(clk), .reset(rst), .rs1(rs1), .rs2(rs2),
    .issue_valid(iv), .rd_issue(rdi), .wb_valid(wv), .wb_rd(wbrd), .wb_data(wbd),
    .read_data1(rd1_a), .read_data2(rd2_a), .hazard(hz_a), .issue_accept(acc_a),
    .busy_vec(busy_a)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(16)) dut_b (
    .clk(clk), .reset(rst), .rs1(rs1[3:0]), .rs2(rs2[3:0]),
    .issue_valid(iv), .rd_issue(rdi[3:0]), .wb_valid(wv), .wb_rd(wbrd[3:0]), .wb_data(wbd[31:0]),
    .read_data1(rd1_b), .read_data2(rd2_b), .hazard(hz_b), .issue_accept(acc_b),
    .busy_vec(busy_b)
  );

  function automatic int nr(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] dmask(int k);
    return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int ridx(int k, logic [4:0] x);
    return int'(x) % nr(k);
  endfunction

  function automatic logic [63:0] exp_read(int k, logic [4:0] x);
    int i = ridx(k, x);
    if (rst || i == 0) return 64'd0;
    if (wv && ridx(k, wbrd) == i) return wbd & dmask(k);
    return mreg[k][i];
  endfunction

  function automatic logic pending(int k, logic [4:0] x);
    int i = ridx(k, x);
    return mbusy[k][i] && !(wv && ridx(k, wbrd) == i);
  endfunction

  function automatic logic exp_hazard(int k);
    if (rst) return 1'b0;
    return pending(k, rs1) || pending(k, rs2) || (iv && pending(k, rdi));
  endfunction

  function automatic logic [63:0] exp_busy(int k);
    logic [63:0] v = '0;
    for (int i = 0; i < nr(k); i++) v[i] = mbusy[k][i];
    return v;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = '0;
        mbusy[k][i] = 1'b0;
      end
  endtask

  task automatic model_edge(int k);
    logic accept;
    int   w, d;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = '0;
        mbusy[k][i] = 1'b0;
      end
    end else begin
      accept = iv && !exp_hazard(k);
      w = ridx(k, wbrd);
      d = ridx(k, rdi);
      if (wv && w != 0) begin
        mreg[k][w]  = wbd & dmask(k);
        mbusy[k][w] = 1'b0;
      end
      if (accept && d != 0) mbusy[k][d] = 1'b1;
    end
  endtask

  // Checks both instances against the model at the negedge preceding the next edge.
  task automatic settle(string tag);
    @(negedge clk);
    check({tag, ".a.rd1"}, rd1_a, exp_read(0, rs1));
    check({tag, ".a.rd2"}, rd2_a, exp_read(0, rs2));
    check({tag, ".a.hz"}, {63'd0, hz_a}, {63'd0, exp_hazard(0)});
    check({tag, ".a.acc"}, {63'd0, acc_a}, {63'd0, iv && !rst && !exp_hazard(0)});
    check({tag, ".a.busy"}, {32'd0, busy_a}, exp_busy(0));
    check({tag, ".b.rd1"}, {32'd0, rd1_b}, exp_read(1, rs1));
    check({tag, ".b.rd2"}, {32'd0, rd2_b}, exp_read(1, rs2));
    check({tag, ".b.hz"}, {63'd0, hz_b}, {63'd0, exp_hazard(1)});
    check({tag, ".b.acc"}, {63'd0, acc_b}, {63'd0, iv && !rst && !exp_hazard(1)});
    check({tag, ".b.busy"}, {48'd0, busy_b}, exp_busy(1));
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rs1 = '0; rs2 = '0; iv = 1'b0; rdi = '0;
    wv = 1'b0; wbrd = '0; wbd = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    settle("reset");
    check("reset.busy_a", {32'd0, busy_a}, 64'd0);
    edge_step();

    // write x5 then read it back; x0 reads zero
    idle(); wv = 1'b1; wbrd = 5'd5; wbd = 64'hDEAD_BEEF;
    settle("wb5"); edge_step();
    idle(); rs1 = 5'd5; rs2 = 5'd0;
    settle("rd5");
    check("rd5.const", rd1_a, 64'hDEAD_BEEF);
    check("rd5.b.const", {32'd0, rd1_b}, 64'hDEAD_BEEF);
    check("rd0.const", rd2_a, 64'd0);
    edge_step();

    // bypass, then write to x0 dropped
    idle(); wv = 1'b1; wbrd = 5'd7; wbd = 64'h1234; rs1 = 5'd7;
    settle("byp7");
    check("byp7.const", rd1_a, 64'h1234);
    edge_step();
    idle(); wv = 1'b1; wbrd = 5'd0; wbd = 64'hFF; rs1 = 5'd0;
    settle("wb0"); edge_step();
    idle(); rs1 = 5'd0; rs2 = 5'd7;
    settle("rd0");
    check("rd0.after", rd1_a, 64'd0);
    edge_step();

    // issue x3, hazard on read, cleared by same-cycle writeback
    idle(); iv = 1'b1; rdi = 5'd3;
    settle("iss3");
    check("iss3.acc", {63'd0, acc_a}, 64'd1);
    edge_step();
    check("iss3.busy", {63'd0, busy_a[3]}, 64'd1);
    idle(); rs1 = 5'd3; iv = 1'b1; rdi = 5'd10;
    settle("raw3");
    check("raw3.hz", {63'd0, hz_a}, 64'd1);
    check("raw3.acc", {63'd0, acc_a}, 64'd0);
    edge_step();
    idle(); rs1 = 5'd3; wv = 1'b1; wbrd = 5'd3; wbd = 64'hABC;
    settle("wb3");
    check("wb3.hz", {63'd0, hz_a}, 64'd0);
    check("wb3.byp", rd1_a, 64'hABC);
    edge_step();

    // same-index set and clear, then WAW
    idle(); iv = 1'b1; rdi = 5'd9; wv = 1'b1; wbrd = 5'd9; wbd = 64'h99;
    settle("setclr9"); edge_step();
    check("setclr9.busy", {63'd0, busy_a[9]}, 64'd1);
    idle(); iv = 1'b1; rdi = 5'd9;
    settle("waw9");
    check("waw9.hz", {63'd0, hz_a}, 64'd1);
    edge_step();
    idle(); iv = 1'b1; rdi = 5'd12; wv = 1'b1; wbrd = 5'd9; wbd = 64'h42;
    settle("diff"); edge_step();
    idle(); wv = 1'b1; wbrd = 5'd15; wbd = 64'hF00D_CAFE_1234_5678;
    settle("wb15"); edge_step();
    idle(); rs2 = 5'd15; rs1 = 5'd12;
    settle("rd15"); edge_step();

    // reset discards pending writeback and busy bits
    idle(); iv = 1'b1; rdi = 5'd4;
    settle("iss4"); edge_step();
    idle(); wv = 1'b1; wbrd = 5'd4; wbd = 64'h55;
    settle("wb4"); edge_step();
    idle(); rst = 1'b1; wv = 1'b1; wbrd = 5'd4; wbd = 64'h77; iv = 1'b1; rdi = 5'd6; rs1 = 5'd4;
    settle("rstmid");
    check("rstmid.rd1", rd1_a, 64'd0);
    edge_step();
    idle(); rs1 = 5'd4; rs2 = 5'd12;
    settle("postrst");
    check("postrst.busy", {32'd0, busy_a}, 64'd0);
    edge_step();

    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 59) == 0);
      rs1  = 5'($urandom); rs2 = 5'($urandom);
      iv   = 1'($urandom); rdi = 5'($urandom);
      wv   = ($urandom_range(0, 2) != 0);
      wbrd = ($urandom_range(0, 1) == 0) ? rdi : 5'($urandom);
      wbd  = {$urandom, $urandom};
      settle("rand");
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
